// File: rtl/ext_arbiter_pkg.sv
// rtl/ext_arbiter_pkg.sv - shared peripheral select codes, state encoding and defaults
package ext_arbiter_pkg;

  localparam logic [2:0] EXT_DISABLE = 3'b000;
  localparam logic [2:0] EXT_ADC     = 3'b001;
  localparam logic [2:0] EXT_DAC     = 3'b010;
  localparam logic [2:0] EXT_SWI     = 3'b100;

  localparam int EXT_CLK_DIV = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } ext_state_t;

  // only the three defined peripheral codes count as a legal select
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == EXT_ADC) || (v == EXT_DAC) || (v == EXT_SWI);
  endfunction

endpackage

// File: rtl/ext_shifter.sv
// rtl/ext_shifter.sv - sclk divider, bit counter and sdo/sdi shift registers
module ext_shifter
  import ext_arbiter_pkg::*;
#(
  parameter int CLK_DIV = EXT_CLK_DIV,
  parameter int DATA_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] wdata,
  input  logic              active,
  input  logic              shifting,
  input  logic              restart,
  input  logic              sdi,
  output logic              div_done,
  output logic              bit_last,
  output logic              sclk,
  output logic              sdo,
  output logic [DATA_W-1:0] rx_data
);

  localparam int BW = $clog2(DATA_W + 1);

  logic [7:0]        div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              sclk_q;

  assign div_done = (div_cnt == 8'(CLK_DIV - 1));
  assign bit_last = (bit_cnt == BW'(DATA_W - 1));
  assign sclk     = sclk_q;
  assign sdo      = active & tx_sr[DATA_W-1];
  assign rx_data  = rx_sr;

  // half-period divider; sclk toggles on divider wrap, rx samples on the rise, tx advances on the fall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      sclk_q  <= 1'b0;
    end else begin
      if (load) begin
        tx_sr <= wdata;
      end
      if (restart) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        sclk_q  <= 1'b0;
      end else if (active) begin
        if (!div_done) begin
          div_cnt <= div_cnt + 8'd1;
        end else begin
          div_cnt <= '0;
          if (shifting) begin
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              rx_sr <= {rx_sr[DATA_W-2:0], sdi};
            end else begin
              tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/ext_arbiter.sv
// rtl/ext_arbiter.sv - round-robin arbiter between MC and host for the serial peripheral bus
module ext_arbiter
  import ext_arbiter_pkg::*;
#(
  parameter int CLK_DIV = EXT_CLK_DIV,
  parameter int DATA_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_mc,
  input  logic              req_host,
  input  logic [2:0]        cs_mc,
  input  logic [2:0]        cs_host,
  input  logic [DATA_W-1:0] wdata_mc,
  input  logic [DATA_W-1:0] wdata_host,
  output logic              ack_mc,
  output logic              ack_host,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [2:0]        ext_cs,
  output logic              sclk,
  output logic              sdo,
  input  logic              sdi
);

  ext_state_t        state, state_nx;
  logic              gnt_host, last_host, err_pend;
  logic [2:0]        cs_q, sel_cs;
  logic [DATA_W-1:0] sel_wdata, rx_data;
  logic              pick_host, grant, div_done, bit_last, finish_ok, finish;

  // the requester not served last wins a tie; no grant while an ack or error is being reported
  assign pick_host = req_host & (~req_mc | ~last_host);
  assign grant     = (state == ST_IDLE) & (req_mc | req_host) & ~err_pend & ~ack_mc & ~ack_host;
  assign sel_cs    = pick_host ? cs_host : cs_mc;
  assign sel_wdata = pick_host ? wdata_host : wdata_mc;
  assign finish_ok = (state == ST_HOLD) & div_done;
  assign finish    = finish_ok | err_pend;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // next-state: a bad select never leaves IDLE, the error is reported from err_pend instead
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (grant && is_onehot3(sel_cs)) state_nx = ST_SETUP;
      ST_SETUP: if (div_done) state_nx = ST_SHIFT;
      ST_SHIFT: if (div_done && sclk && bit_last) state_nx = ST_HOLD;
      ST_HOLD:  if (div_done) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    busy   = (state != ST_IDLE) | err_pend;
    ext_cs = (state != ST_IDLE) ? cs_q : EXT_DISABLE;
  end

  // grant bookkeeping, one-cycle ack/err pulses and rdata capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_host  <= 1'b0;
      last_host <= 1'b1;
      err_pend  <= 1'b0;
      cs_q      <= EXT_DISABLE;
      ack_mc    <= 1'b0;
      ack_host  <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      ack_mc   <= finish & ~gnt_host;
      ack_host <= finish & gnt_host;
      err      <= err_pend;
      if (grant) begin
        gnt_host  <= pick_host;
        last_host <= pick_host;
        cs_q      <= sel_cs;
        err_pend  <= ~is_onehot3(sel_cs);
      end else begin
        err_pend  <= 1'b0;
      end
      if (finish_ok) rdata <= rx_data;
    end
  end

  ext_shifter #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (grant),
    .wdata    (sel_wdata),
    .active   (state != ST_IDLE),
    .shifting (state == ST_SHIFT),
    .restart  (state_nx != state),
    .sdi      (sdi),
    .div_done (div_done),
    .bit_last (bit_last),
    .sclk     (sclk),
    .sdo      (sdo),
    .rx_data  (rx_data)
  );

endmodule

// File: tb/tb_ext_arbiter.sv
// tb/tb_ext_arbiter.sv - scoreboard bench for ext_arbiter
module tb_ext_arbiter;

  localparam int DW  = 24;
  localparam int CD  = 2;
  localparam int LAT = CD * (2 * DW + 2);

  typedef struct packed {
    logic          host;
    logic          err;
    logic [DW-1:0] rdata;
    logic [2:0]    cs;
  } exp_t;

  logic clk;
  logic rst;
  logic req_mc, req_host, ack_mc, ack_host, err, busy, sclk, sdo, sdi;
  logic [2:0] cs_mc, cs_host, ext_cs;
  logic [DW-1:0] wdata_mc, wdata_host, rdata;
  int sdi_mode;

  logic req1, ack_mc1, ack_host1, err1, busy1, sclk1, sdo1;
  logic [2:0] ext_cs1;
  logic [DW-1:0] wdata1, rdata1;

  exp_t exp_q[$];
  int n_chk, n_fail;
  logic model_last_host;
  logic [DW-1:0] model_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (sdi_mode)
      0:       sdi = sdo;
      1:       sdi = ~sdo;
      2:       sdi = 1'b0;
      default: sdi = 1'b1;
    endcase
  end

  ext_arbiter #(.CLK_DIV(CD), .DATA_W(DW)) u_dut (
    .clk(clk), .rst(rst),
    .req_mc(req_mc), .req_host(req_host),
    .cs_mc(cs_mc), .cs_host(cs_host),
    .wdata_mc(wdata_mc), .wdata_host(wdata_host),
    .ack_mc(ack_mc), .ack_host(ack_host), .err(err), .rdata(rdata),
    .busy(busy), .ext_cs(ext_cs), .sclk(sclk), .sdo(sdo), .sdi(sdi)
  );

  ext_arbiter #(.CLK_DIV(1), .DATA_W(DW)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_mc(req1), .req_host(1'b0),
    .cs_mc(3'b001), .cs_host(3'b000),
    .wdata_mc(wdata1), .wdata_host({DW{1'b0}}),
    .ack_mc(ack_mc1), .ack_host(ack_host1), .err(err1), .rdata(rdata1),
    .busy(busy1), .ext_cs(ext_cs1), .sclk(sclk1), .sdo(sdo1), .sdi(1'b0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic logic [DW-1:0] model_rx(input logic [DW-1:0] w, input int mode);
    case (mode)
      0:       return w;
      1:       return ~w;
      2:       return '0;
      default: return '1;
    endcase
  endfunction

  task automatic model_serve(input logic host, input logic [2:0] cs, input logic [DW-1:0] w);
    exp_t e;
    e.host = host;
    e.cs   = cs;
    e.err  = ($countones(cs) != 1);
    if (!e.err) model_rdata = model_rx(w, sdi_mode);
    e.rdata = model_rdata;
    model_last_host = host;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] pick_cs();
    logic [2:0] codes [3];
    codes[0] = 3'b001; codes[1] = 3'b010; codes[2] = 3'b100;
    if ($urandom_range(0, 3) == 3) return 3'($urandom);
    return codes[$urandom_range(0, 2)];
  endfunction

  // single or paired request; singles may scramble inputs or drop req after grant
  task automatic run_txn(input bit use_mc, input bit use_host,
                         input logic [2:0] cmc, input logic [2:0] chost,
                         input logic [DW-1:0] wmc, input logic [DW-1:0] whost,
                         input bit scramble, input int drop_at);
    bit pm, ph;
    int t, bc;
    if (use_mc && use_host) begin
      if (model_last_host) begin
        model_serve(1'b0, cmc, wmc); model_serve(1'b1, chost, whost);
      end else begin
        model_serve(1'b1, chost, whost); model_serve(1'b0, cmc, wmc);
      end
    end else if (use_mc) model_serve(1'b0, cmc, wmc);
    else model_serve(1'b1, chost, whost);
    cs_mc = cmc; cs_host = chost; wdata_mc = wmc; wdata_host = whost;
    req_mc = use_mc; req_host = use_host;
    pm = use_mc; ph = use_host;
    t = 0; bc = 0;
    while ((pm || ph) && t < 1000) begin
      tick();
      t++;
      if (ack_mc) begin pm = 0; req_mc = 1'b0; end
      if (ack_host) begin ph = 0; req_host = 1'b0; end
      if (busy && !(use_mc && use_host)) begin
        bc++;
        if (scramble) begin
          cs_mc = 3'($urandom); cs_host = 3'($urandom);
          wdata_mc = DW'($urandom); wdata_host = DW'($urandom);
        end
        if (drop_at != 0 && bc >= drop_at) begin req_mc = 1'b0; req_host = 1'b0; end
      end
    end
    if (pm || ph) begin
      n_chk++; n_fail++;
      $display("FAIL txn_timeout: got no ack after %0d cycles, expected ack", t);
      req_mc = 1'b0; req_host = 1'b0;
      exp_q.delete();
    end
    tick();
  endtask

  // scoreboard monitor: pops on every ack, also tracks select, sclk rises and sdo timing
  initial begin : monitor
    int cyc, setup_cyc, rises;
    logic saw_cs, p_sclk, p_sdo, p_ack;
    logic [2:0] p_cs, first_cs;
    exp_t e;
    cyc = 0; setup_cyc = 0; rises = 0; saw_cs = 0;
    p_sclk = 0; p_sdo = 0; p_ack = 0; p_cs = 0; first_cs = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        saw_cs = 0; rises = 0; p_ack = 0; p_sclk = 0; p_cs = 0; p_sdo = 0;
      end else begin
        if (p_ack) begin
          check("busy_after_ack", busy, 0);
          check("cs_after_ack", ext_cs, 0);
        end
        if (ext_cs != 0 && p_cs == 0) begin
          setup_cyc = cyc; first_cs = ext_cs; saw_cs = 1;
        end
        if (ext_cs != 0 && p_cs != 0 && sdo !== p_sdo)
          check("sdo_only_on_fall", {p_sclk, sclk}, 2'b10);
        if (sclk && !p_sclk) rises++;
        if (ack_mc || ack_host) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_ack: got ack_mc=%0b ack_host=%0b, expected none", ack_mc, ack_host);
          end else begin
            e = exp_q.pop_front();
            check("ack_who", {ack_host, ack_mc}, e.host ? 2'b10 : 2'b01);
            check("err", err, e.err);
            check("rdata", rdata, e.rdata);
            if (e.err) begin
              check("err_no_cs", saw_cs, 0);
              check("err_no_sclk", rises, 0);
            end else begin
              check("latency", cyc - setup_cyc, LAT);
              check("ext_cs", first_cs, e.cs);
              check("sclk_rises", rises, DW);
            end
          end
          saw_cs = 0; rises = 0;
        end
        p_ack = ack_mc | ack_host; p_cs = ext_cs; p_sclk = sclk; p_sdo = sdo;
      end
    end
  end

  initial begin : stim
    int t, rises, start, ack_t;
    logic ps;
    logic [DW-1:0] word;
    n_chk = 0; n_fail = 0;
    model_last_host = 1'b1; model_rdata = '0;
    rst = 1'b0; sdi_mode = 0;
    req_mc = 0; req_host = 0; cs_mc = 0; cs_host = 0; wdata_mc = 0; wdata_host = 0;
    req1 = 0; wdata1 = 0;
    repeat (3) tick();
    check("rst_ack_mc", ack_mc, 0);
    check("rst_ack_host", ack_host, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_ext_cs", ext_cs, 0);
    check("rst_sclk", sclk, 0);
    check("rst_sdo", sdo, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b1;
    tick();

    // tie twice back-to-back: MC, host, then re-raised MC
    sdi_mode = 0;
    model_serve(1'b0, 3'b001, 24'h111111);
    model_serve(1'b1, 3'b010, 24'h222222);
    model_serve(1'b0, 3'b100, 24'h333333);
    cs_mc = 3'b001; wdata_mc = 24'h111111; cs_host = 3'b010; wdata_host = 24'h222222;
    req_mc = 1; req_host = 1;
    t = 0; rises = 0;
    while (rises < 3 && t < 1000) begin
      tick(); t++;
      if (ack_mc) begin
        rises++;
        if (rises == 1) begin cs_mc = 3'b100; wdata_mc = 24'h333333; end
        else req_mc = 0;
      end
      if (ack_host) begin rises++; req_host = 0; end
    end
    check("rr_three_acks", rises, 3);
    req_mc = 0; req_host = 0;
    tick();

    run_txn(1, 0, 3'b001, 3'b000, 24'hA5A5A5, 24'h0, 0, 0);
    run_txn(0, 1, 3'b000, 3'b011, 24'h0, 24'h123456, 0, 0);
    run_txn(1, 0, 3'b010, 3'b000, 24'h5A0F3C, 24'h0, 1, LAT - 1);

    for (int i = 0; i < 30; i++) begin
      int kind;
      sdi_mode = $urandom_range(0, 3);
      kind = $urandom_range(0, 2);
      run_txn(kind != 1, kind != 0, pick_cs(), pick_cs(), DW'($urandom), DW'($urandom),
              (kind != 2) && $urandom_range(0, 1) == 1,
              (kind != 2) ? $urandom_range(0, 105) : 0);
    end

    // reset while shifting bit 10
    sdi_mode = 0;
    cs_mc = 3'b100; wdata_mc = 24'hC3C3C3; req_mc = 1;
    t = 0; rises = 0; ps = 0;
    while (rises < 11 && t < 500) begin
      tick(); t++;
      if (sclk && !ps) rises++;
      ps = sclk;
    end
    check("reached_bit10", rises, 11);
    #3 rst = 1'b0;
    #1;
    check("midrst_ext_cs", ext_cs, 0);
    check("midrst_sclk", sclk, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rdata", rdata, 0);
    req_mc = 0;
    exp_q.delete();
    model_last_host = 1'b1; model_rdata = '0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    run_txn(1, 0, 3'b001, 3'b000, 24'h0F1E2D, 24'h0, 0, 0);

    // CLK_DIV=1 instance: sdo waveform captured on sclk rises
    wdata1 = 24'h800001; req1 = 1;
    t = 0; rises = 0; start = -1; ack_t = -1; ps = 0; word = '0;
    while (ack_t < 0 && t < 200) begin
      @(negedge clk); t++;
      if (sclk1 && !ps) begin rises++; word = {word[DW-2:0], sdo1}; end
      ps = sclk1;
      if (ext_cs1 != 0 && start < 0) start = t;
      if (ack_mc1) begin
        ack_t = t; req1 = 0;
        check("div1_err", err1, 0);
        check("div1_rdata", rdata1, 0);
      end
    end
    req1 = 0;
    check("div1_acked", ack_t >= 0, 1);
    check("div1_rises", rises, DW);
    check("div1_sdo_word", word, 24'h800001);
    check("div1_latency", ack_t - start, 2 * DW + 2);
    repeat (3) tick();

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
